multi_cycle_controller: RTL and testbench
=========================================

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: HALT_ON_ILLEGAL, default 1, meaning 1 = stay in ILLEGAL until reset, 0 = return to FETCH after one cycle.
REQ-003 Parameter: ALUCTL_W, default 3, meaning ALUControl width, minimum 3, upper bits 0.
REQ-004 Ports, in order (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- op  in  7  instruction opcode
- func3  in  3  instruction func3
- func7  in  7  instruction func7
- Zero  in  1  ALU result zero
- ALU_sine  in  1  ALU result sign bit
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data write enable
- IRWrite  out  1  instruction/OldPC register enable
- RegWrite  out  1  register-file write enable
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
- ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
- ALUControl  out  ALUCTL_W  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor
- ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
- Illegal  out  1  high while in ILLEGAL
- state_o  out  4  current state encoding, for debug

Function
REQ-005 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, JAL, JALR, JALRLINK, BRANCH, LUI, ILLEGAL. state_o is the 0-based index in this order.
REQ-006 Unlisted outputs are 0 in every state, which gives add, I-imm and PC sources.
REQ-007 FETCH: IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10. Next state is DECODE.
REQ-008 DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=100 if op=1101111 else 010. Next state by op:
- 0000011 or 0100011: MEMADR
- 0110011: EXECR
- 0010011: EXECI
- 1101111: JAL
- 1100111: JALR
- 1100011: BRANCH
- 0110111: LUI
- any other op: ILLEGAL
REQ-009 DECODE SHALL also go to ILLEGAL on unsupported codes:
- R-type func7/func3 other than add, sub, and, or, slt
- I-type func3 other than 000, 100, 110, 010
- branch func3 other than 000, 001, 100, 101
REQ-010 MEMADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=001 for store else 000. Next state is MEMWRITE for 0100011, else MEMREAD.
REQ-011 MEMREAD: AdrSrc=1, then MEMWB. MEMWB: ResultSrc=01, RegWrite=1, then FETCH. MEMWRITE: AdrSrc=1, MemWrite=1, then FETCH.
REQ-012 EXECR: ALUSrcA=10, ALUSrcB=00, ALUControl decoded from func7/func3 (add 000, sub 001, and 010, or 011, slt 100). Next state is ALUWB.
REQ-013 EXECI: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUControl from func3 (000 add, 100 xor, 110 or, 010 slt). Next state is ALUWB.
REQ-014 ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
REQ-015 JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, then ALUWB, which writes OldPC+4.
REQ-016 JALR: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, PCWrite=1, then JALRLINK. JALRLINK: ALUSrcA=01, ALUSrcB=10, then ALUWB.
REQ-017 BRANCH: ALUSrcA=10, ALUSrcB=00, ALUControl=001, ResultSrc=00. PCWrite is combinational from Zero/ALU_sine in the same cycle:
- beq: Zero
- bne: ~Zero
- blt: ALU_sine
- bge: ~ALU_sine
Next state is FETCH.
REQ-018 LUI: ImmSrc=011, ResultSrc=11, RegWrite=1, then FETCH.
REQ-019 ILLEGAL: Illegal=1 and all enables 0. Next state is ILLEGAL if HALT_ON_ILLEGAL=1, else FETCH.
REQ-020 Outputs SHALL be combinational from state (and inputs where stated above). Only the state register is sequential. CPI is 3 for branch/LUI, 4 for R/I/JAL/sw, 5 for lw/JALR.

Reset
REQ-021 If rst is high at a rising edge, the state SHALL become FETCH, overriding any transition, in every state including ILLEGAL.
REQ-022 While rst is high, PCWrite, IRWrite, MemWrite and RegWrite SHALL be forced to 0 and Illegal to 0.
REQ-023 After rst is released, the first cycle SHALL be FETCH with state_o=0.

Verification
REQ-024 Release reset, op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 and ResultSrc=01 only in MEMWB.
REQ-025 op=1100011, func3=000 -> PCWrite=1 in BRANCH when Zero=1, 0 when Zero=0. With func3=100, ALU_sine=1 -> PCWrite=1.
REQ-026 op=0110011, func7=0100000, func3=000 -> ALUControl=001 in EXECR, then RegWrite=1 in ALUWB.
REQ-027 op=1100111 -> FETCH, DECODE, JALR (PCWrite=1, ResultSrc=10), JALRLINK, ALUWB, FETCH.
REQ-028 op=1111111 -> ILLEGAL with Illegal=1; it holds for 10 cycles when HALT_ON_ILLEGAL=1, and returns to FETCH next cycle when HALT_ON_ILLEGAL=0.
REQ-029 Assert rst during MEMWRITE -> MemWrite=0 that cycle and FETCH next cycle.

Source files
------------

// File: rtl/multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// multi_cycle_controller
//
// Main control FSM for a multi-cycle RV32I-subset datapath. Each instruction
// starts in FETCH, is classified in DECODE and then walks a short,
// opcode-specific state sequence back to FETCH. Unsupported opcodes and
// function codes trap to ILLEGAL.
//
// Parameters
//   HALT_ON_ILLEGAL : 1 = ILLEGAL is sticky until reset,
//                     0 = ILLEGAL lasts one cycle, then FETCH
//   ALUCTL_W        : width of ALUControl (>= 3); bits above [2:0] are 0
//
// Ports
//   clk, rst         : clock (rising edge) and synchronous active-high reset
//   op/func3/func7   : instruction fields from the instruction register
//   Zero, ALU_sine   : ALU flags, used only for the branch decision
//   PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
//   ALUSrcB, ALUControl, ImmSrc : datapath controls
//   Illegal          : high while in ILLEGAL
//   state_o          : current state index (debug)
//
// All outputs are combinational from the state register (plus op/func and
// the ALU flags where noted). While rst is high every write enable and
// Illegal is held low so a reset can never commit a half-finished access.
// ---------------------------------------------------------------------------
module multi_cycle_controller #(
  parameter bit HALT_ON_ILLEGAL = 1'b1,
  parameter int ALUCTL_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          op,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                Zero,
  input  logic                ALU_sine,
  output logic                PCWrite,
  output logic                AdrSrc,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic [1:0]          ResultSrc,
  output logic [1:0]          ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUCTL_W-1:0] ALUControl,
  output logic [2:0]          ImmSrc,
  output logic                Illegal,
  output logic [3:0]          state_o
);

  // -------------------------------------------------------------------------
  // Encodings
  // -------------------------------------------------------------------------
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALRLINK = 4'd11,
    S_BRANCH   = 4'd12,
    S_LUI      = 4'd13,
    S_ILLEGAL  = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // Function-code decode, shared by DECODE (legality) and the execute
  // states (ALU operation / branch condition).
  // -------------------------------------------------------------------------
  logic       r_legal;
  logic [2:0] r_alu;
  logic       i_legal;
  logic [2:0] i_alu;
  logic       br_legal;
  logic       br_taken;

  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    case ({func7, func3})
      {F7_BASE, 3'b000}: r_alu = ALU_ADD;
      {F7_ALT,  3'b000}: r_alu = ALU_SUB;
      {F7_BASE, 3'b111}: r_alu = ALU_AND;
      {F7_BASE, 3'b110}: r_alu = ALU_OR;
      {F7_BASE, 3'b010}: r_alu = ALU_SLT;
      default:           r_legal = 1'b0;
    endcase
  end

  always_comb begin
    i_legal = 1'b1;
    i_alu   = ALU_ADD;
    case (func3)
      3'b000:  i_alu = ALU_ADD;
      3'b100:  i_alu = ALU_XOR;
      3'b110:  i_alu = ALU_OR;
      3'b010:  i_alu = ALU_SLT;
      default: i_legal = 1'b0;
    endcase
  end

  // The datapath computes RD1 - RD2 in BRANCH, so the decision only needs
  // the zero and sign flags of that subtraction.
  always_comb begin
    br_legal = 1'b1;
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = Zero;        // beq
      3'b001:  br_taken = ~Zero;       // bne
      3'b100:  br_taken = ALU_sine;    // blt
      3'b101:  br_taken = ~ALU_sine;   // bge
      default: br_legal = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = r_legal  ? S_EXECR  : S_ILLEGAL;
          OP_ITYPE:          state_d = i_legal  ? S_EXECI  : S_ILLEGAL;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = br_legal ? S_BRANCH : S_ILLEGAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      // JAL redirects the PC first, then ALUWB writes back OldPC+4.
      S_JAL:      state_d = S_ALUWB;
      // JALR needs an extra cycle because the ALU is busy with the target
      // when the link value would otherwise be formed.
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_ALUWB;
      S_BRANCH:   state_d = S_FETCH;
      S_LUI:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = HALT_ON_ILLEGAL ? S_ILLEGAL : S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode. Everything defaults to 0, which is add / I-imm / PC.
  // -------------------------------------------------------------------------
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_ctl;
  logic [2:0] imm_src;
  logic       illegal;

  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_ctl    = ALU_ADD;
    imm_src    = IMM_I;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight from the ALU result into the PC.
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      S_DECODE: begin
        // Speculatively form OldPC+imm as a branch/jump target.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = (op == OP_STORE) ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_ctl   = r_alu;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_I;
        alu_ctl   = i_alu;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
      end
      S_JAL: begin
        // ALUOut still holds the DECODE target; meanwhile form OldPC+4.
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        result_src = RES_ALURES;
        pc_write   = 1'b1;
      end
      S_JALRLINK: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
      end
      S_BRANCH: begin
        // ALUOut holds the DECODE target; the compare happens this cycle.
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_ctl    = ALU_SUB;
        result_src = RES_ALUOUT;
        pc_write   = br_taken;
      end
      S_LUI: begin
        imm_src    = IMM_U;
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Port drive. Write enables and Illegal are suppressed during reset.
  // -------------------------------------------------------------------------
  assign PCWrite   = pc_write  & ~rst;
  assign IRWrite   = ir_write  & ~rst;
  assign MemWrite  = mem_write & ~rst;
  assign RegWrite  = reg_write & ~rst;
  assign Illegal   = illegal   & ~rst;
  assign AdrSrc    = adr_src;
  assign ResultSrc = result_src;
  assign ALUSrcA   = alu_src_a;
  assign ALUSrcB   = alu_src_b;
  assign ImmSrc    = imm_src;
  assign state_o   = state_q;

  // ALUControl is zero-extended to whatever width the datapath wants.
  assign ALUControl[2:0] = alu_ctl;

  genvar gi;
  generate
    for (gi = 3; gi < ALUCTL_W; gi++) begin : g_aluctl_pad
      assign ALUControl[gi] = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_multi_cycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_controller
//
// Two instances share one stimulus stream: u_halt (HALT_ON_ILLEGAL=1,
// ALUCTL_W=3) and u_nohalt (HALT_ON_ILLEGAL=0, ALUCTL_W=4). The reference
// model expands each instruction into its list of visited states and looks
// up the expected control word for each state from the control table.
// Every cycle both instances are compared in full.
// ---------------------------------------------------------------------------
module tb_multi_cycle_controller;

  localparam int S_FETCH    = 0;
  localparam int S_DECODE   = 1;
  localparam int S_MEMADR   = 2;
  localparam int S_MEMREAD  = 3;
  localparam int S_MEMWB    = 4;
  localparam int S_MEMWRITE = 5;
  localparam int S_EXECR    = 6;
  localparam int S_EXECI    = 7;
  localparam int S_ALUWB    = 8;
  localparam int S_JAL      = 9;
  localparam int S_JALR     = 10;
  localparam int S_JALRLINK = 11;
  localparam int S_BRANCH   = 12;
  localparam int S_LUI      = 13;
  localparam int S_ILLEGAL  = 14;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       Zero;
  logic       ALU_sine;

  logic       PCWrite_h, AdrSrc_h, MemWrite_h, IRWrite_h, RegWrite_h, Illegal_h;
  logic [1:0] ResultSrc_h, ALUSrcA_h, ALUSrcB_h;
  logic [2:0] ALUControl_h, ImmSrc_h;
  logic [3:0] state_o_h;

  logic       PCWrite_n, AdrSrc_n, MemWrite_n, IRWrite_n, RegWrite_n, Illegal_n;
  logic [1:0] ResultSrc_n, ALUSrcA_n, ALUSrcB_n;
  logic [3:0] ALUControl_n;
  logic [2:0] ImmSrc_n;
  logic [3:0] state_o_n;

  multi_cycle_controller #(.HALT_ON_ILLEGAL(1'b1), .ALUCTL_W(3)) u_halt (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .ALU_sine(ALU_sine),
    .PCWrite(PCWrite_h), .AdrSrc(AdrSrc_h), .MemWrite(MemWrite_h),
    .IRWrite(IRWrite_h), .RegWrite(RegWrite_h), .ResultSrc(ResultSrc_h),
    .ALUSrcA(ALUSrcA_h), .ALUSrcB(ALUSrcB_h), .ALUControl(ALUControl_h),
    .ImmSrc(ImmSrc_h), .Illegal(Illegal_h), .state_o(state_o_h)
  );

  multi_cycle_controller #(.HALT_ON_ILLEGAL(1'b0), .ALUCTL_W(4)) u_nohalt (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
    .Zero(Zero), .ALU_sine(ALU_sine),
    .PCWrite(PCWrite_n), .AdrSrc(AdrSrc_n), .MemWrite(MemWrite_n),
    .IRWrite(IRWrite_n), .RegWrite(RegWrite_n), .ResultSrc(ResultSrc_n),
    .ALUSrcA(ALUSrcA_n), .ALUSrcB(ALUSrcB_n), .ALUControl(ALUControl_n),
    .ImmSrc(ImmSrc_n), .Illegal(Illegal_n), .state_o(state_o_n)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit rand_zs     = 1'b0;
  int q_h[$];
  int q_n[$];
  int last_h      = S_FETCH;
  int last_n      = S_FETCH;
  int seq_buf[5];
  int seq_len;

  // ---- reference model: visited states per instruction --------------------
  task automatic build_seq(input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7);
    bit r_ok, i_ok, b_ok;
    r_ok = ((f7 == 7'b0000000) && (f3 == 3'b000 || f3 == 3'b111 ||
                                   f3 == 3'b110 || f3 == 3'b010)) ||
           ((f7 == 7'b0100000) && (f3 == 3'b000));
    i_ok = (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b110 || f3 == 3'b010);
    b_ok = (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101);
    seq_buf[0] = S_FETCH;
    seq_buf[1] = S_DECODE;
    seq_buf[2] = S_ILLEGAL;
    seq_buf[3] = 0;
    seq_buf[4] = 0;
    seq_len    = 3;
    case (o)
      7'b0000011: begin seq_buf[2] = S_MEMADR; seq_buf[3] = S_MEMREAD;
                        seq_buf[4] = S_MEMWB; seq_len = 5; end
      7'b0100011: begin seq_buf[2] = S_MEMADR; seq_buf[3] = S_MEMWRITE; seq_len = 4; end
      7'b0110011: if (r_ok) begin seq_buf[2] = S_EXECR; seq_buf[3] = S_ALUWB; seq_len = 4; end
      7'b0010011: if (i_ok) begin seq_buf[2] = S_EXECI; seq_buf[3] = S_ALUWB; seq_len = 4; end
      7'b1101111: begin seq_buf[2] = S_JAL; seq_buf[3] = S_ALUWB; seq_len = 4; end
      7'b1100111: begin seq_buf[2] = S_JALR; seq_buf[3] = S_JALRLINK;
                        seq_buf[4] = S_ALUWB; seq_len = 5; end
      7'b1100011: if (b_ok) seq_buf[2] = S_BRANCH;
      7'b0110111: seq_buf[2] = S_LUI;
      default:    seq_buf[2] = S_ILLEGAL;
    endcase
  endtask

  // ---- reference model: control word per state -----------------------------
  // Packing: pcw adr mw irw rw rs[2] sa[2] sb[2] alu[4] imm[3] ill st[4]
  function automatic logic [22:0] exp_out(input int st, input logic [6:0] o,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic z, input logic sn, input logic r);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] rs, sa, sb;
    logic [3:0] alu;
    logic [2:0] imm;
    logic [3:0] st4;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; alu = 4'd0; imm = 3'b000;
    st4 = st[3:0];
    case (st)
      S_FETCH:    begin irw = 1; pcw = 1; sb = 2'b10; rs = 2'b10; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b01;
                        imm = (o == 7'b1101111) ? 3'b100 : 3'b010; end
      S_MEMADR:   begin sa = 2'b10; sb = 2'b01;
                        imm = (o == 7'b0100011) ? 3'b001 : 3'b000; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXECR: begin
        sa = 2'b10; sb = 2'b00;
        if (f7 == 7'b0100000 && f3 == 3'b000) alu = 4'd1;
        else if (f3 == 3'b111) alu = 4'd2;
        else if (f3 == 3'b110) alu = 4'd3;
        else if (f3 == 3'b010) alu = 4'd4;
        else alu = 4'd0;
      end
      S_EXECI: begin
        sa = 2'b10; sb = 2'b01; imm = 3'b000;
        if (f3 == 3'b100) alu = 4'd5;
        else if (f3 == 3'b110) alu = 4'd3;
        else if (f3 == 3'b010) alu = 4'd4;
        else alu = 4'd0;
      end
      S_ALUWB:    begin rs = 2'b00; rw = 1; end
      S_JAL:      begin sa = 2'b01; sb = 2'b10; rs = 2'b00; pcw = 1; end
      S_JALR:     begin sa = 2'b10; sb = 2'b01; rs = 2'b10; pcw = 1; end
      S_JALRLINK: begin sa = 2'b01; sb = 2'b10; end
      S_BRANCH: begin
        sa = 2'b10; sb = 2'b00; alu = 4'd1; rs = 2'b00;
        if (f3 == 3'b000) pcw = z;
        else if (f3 == 3'b001) pcw = ~z;
        else if (f3 == 3'b100) pcw = sn;
        else if (f3 == 3'b101) pcw = ~sn;
      end
      S_LUI:      begin imm = 3'b011; rs = 2'b11; rw = 1; end
      S_ILLEGAL:  ill = 1;
      default:    ill = 0;
    endcase
    if (r) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill, st4};
  endfunction

  // ---- one clock cycle: called just after a falling edge -------------------
  task automatic do_cycle();
    int eh, en;
    logic [22:0] xh, xn, ah, an;
    if (rand_zs) begin
      Zero     = 1'($urandom_range(0, 1));
      ALU_sine = 1'($urandom_range(0, 1));
    end
    if (q_h.size() == 0) begin
      if (last_h == S_ILLEGAL) q_h.push_back(S_ILLEGAL);
      else begin
        build_seq(op, func3, func7);
        for (int i = 0; i < seq_len; i++) q_h.push_back(seq_buf[i]);
      end
    end
    if (q_n.size() == 0) begin
      build_seq(op, func3, func7);
      for (int i = 0; i < seq_len; i++) q_n.push_back(seq_buf[i]);
    end
    eh = q_h.pop_front();
    en = q_n.pop_front();
    last_h = eh;
    last_n = en;
    #1;
    xh = exp_out(eh, op, func3, func7, Zero, ALU_sine, rst);
    xn = exp_out(en, op, func3, func7, Zero, ALU_sine, rst);
    ah = {PCWrite_h, AdrSrc_h, MemWrite_h, IRWrite_h, RegWrite_h, ResultSrc_h,
          ALUSrcA_h, ALUSrcB_h, 1'b0, ALUControl_h, ImmSrc_h, Illegal_h, state_o_h};
    an = {PCWrite_n, AdrSrc_n, MemWrite_n, IRWrite_n, RegWrite_n, ResultSrc_n,
          ALUSrcA_n, ALUSrcB_n, ALUControl_n, ImmSrc_n, Illegal_n, state_o_n};
    vectors++;
    assert (ah === xh) else begin
      miscompares++;
      $error("FAIL halt_ctl st=%0d op=%b f3=%b rst=%0b observed=%h expected=%h",
             eh, op, func3, rst, ah, xh);
    end
    vectors++;
    assert (an === xn) else begin
      miscompares++;
      $error("FAIL nohalt_ctl st=%0d op=%b f3=%b rst=%0b observed=%h expected=%h",
             en, op, func3, rst, an, xn);
    end
    if (rst) begin
      q_h.delete();
      q_n.delete();
      last_h = S_FETCH;
      last_n = S_FETCH;
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    do_cycle();
    do_cycle();
    rst = 1'b0;
    $display("reset applied");
  endtask

  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3,
                           input logic [6:0] f7);
    int cyc;
    op = o; func3 = f3; func7 = f7;
    do_cycle();
    cyc = 1;
    while (q_h.size() != 0 && cyc < 8) begin
      do_cycle();
      cyc++;
    end
    vectors++;
    assert (q_h.size() == 0) else begin
      miscompares++;
      $error("FAIL instr_bound op=%b observed=%0d cycles expected=<=8", o, cyc);
    end
    $display("instr op=%b f3=%b f7=%b cycles=%0d", o, f3, f7, cyc);
  endtask

  initial begin
    logic [6:0] ro, rf7;
    logic [2:0] rf3;
    logic [9:0] rtab [5];
    rtab[0] = {7'b0000000, 3'b000};
    rtab[1] = {7'b0100000, 3'b000};
    rtab[2] = {7'b0000000, 3'b111};
    rtab[3] = {7'b0000000, 3'b110};
    rtab[4] = {7'b0000000, 3'b010};

    rst = 1'b1; op = '0; func3 = '0; func7 = '0; Zero = 1'b0; ALU_sine = 1'b0;
    @(negedge clk);
    reset_dut();

    // load: 0,1,2,3,4 then back to FETCH
    rand_zs = 1'b1;
    run_instr(7'b0000011, 3'b010, 7'd0);

    // branches with controlled flags
    rand_zs = 1'b0;
    Zero = 1'b1; ALU_sine = 1'b0;
    run_instr(7'b1100011, 3'b000, 7'd0);
    Zero = 1'b0;
    run_instr(7'b1100011, 3'b000, 7'd0);
    ALU_sine = 1'b1;
    run_instr(7'b1100011, 3'b100, 7'd0);
    Zero = 1'b1; ALU_sine = 1'b0;
    run_instr(7'b1100011, 3'b001, 7'd0);
    run_instr(7'b1100011, 3'b101, 7'd0);
    rand_zs = 1'b1;

    // sub, jalr, store, lui, jal, xori
    run_instr(7'b0110011, 3'b000, 7'b0100000);
    run_instr(7'b1100111, 3'b000, 7'd0);
    run_instr(7'b0100011, 3'b010, 7'd0);
    run_instr(7'b0110111, 3'b101, 7'd9);
    run_instr(7'b1101111, 3'b011, 7'd3);
    run_instr(7'b0010011, 3'b100, 7'd0);

    // illegal opcode: halting copy holds, the other one restarts
    run_instr(7'b1111111, 3'b000, 7'd0);
    repeat (10) do_cycle();
    reset_dut();

    // unsupported function codes
    run_instr(7'b0110011, 3'b001, 7'b0000000);
    reset_dut();
    run_instr(7'b1100011, 3'b010, 7'd0);
    reset_dut();

    // reset during MEMWRITE
    op = 7'b0100011; func3 = 3'b010; func7 = 7'd0;
    do_cycle(); do_cycle(); do_cycle();
    rst = 1'b1;
    do_cycle();
    do_cycle();
    rst = 1'b0;
    $display("reset during MEMWRITE checked");

    // randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      rf3 = 3'($urandom_range(0, 7));
      rf7 = 7'($urandom_range(0, 127));
      case ($urandom_range(0, 9))
        0: ro = 7'b0000011;
        1: ro = 7'b0100011;
        2: begin
          ro = 7'b0110011;
          if ($urandom_range(0, 7) != 0) {rf7, rf3} = rtab[$urandom_range(0, 4)];
        end
        3: ro = 7'b0010011;
        4: ro = 7'b1101111;
        5: ro = 7'b1100111;
        6: ro = 7'b1100011;
        7: ro = 7'b0110111;
        default: ro = 7'($urandom_range(0, 127));
      endcase
      run_instr(ro, rf3, rf7);
      if (last_h == S_ILLEGAL) begin
        repeat ($urandom_range(1, 4)) do_cycle();
        reset_dut();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
